key_schedule: RTL and testbench

Sequential AES-128 key expansion unit. It accepts a 128-bit cipher key over a valid/accept handshake, iterates the single-step expansion over 10 rounds (one round key per cycle), and stores all 11 round keys (rk[0] = cipher key, rk[1..10] = expanded). It sits directly upstream of the encryption round datapath, which reads round keys by index through a registered read port.

---
 rtl/aes_pkg.sv | 18 +
 rtl/roundkey.sv | 72 +++++++
 rtl/key_schedule.sv | 122 ++++++++++++
 tb/tb_key_schedule.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 key schedule types and constants
//
// Purpose: common constants, round key type and key schedule FSM states.
// Contents: AES_ROUNDS, NUM_RK, rk_t, ks_state_e.
package aes_pkg;

  localparam int AES_ROUNDS = 10;
  localparam int NUM_RK     = 11;

  typedef logic [127:0] rk_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } ks_state_e;

endpackage

// File: rtl/roundkey.sv
// rtl/roundkey.sv - combinational single-round AES-128 key expansion step
//
// Purpose: derive round key r+1 from round key r.
// Ports:
//   inkey  in  128  round key r, byte 0 in [127:120]
//   rc     in  4    round index r (0..9), selects Rcon
//   outkey out 128  round key r+1
module roundkey
  import aes_pkg::*;
(
  input  rk_t        inkey,
  input  logic [3:0] rc,
  output rk_t        outkey
);

  // S-box packed MSB-first: entry 0 lives in [2047:2040].
  localparam logic [2047:0] SBOX_FLAT = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry b sits at bit offset (255-b)*8, and 255-b == ~b for a byte.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_FLAT[{~b, 3'b000} +: 8];
  endfunction

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub, t;
  logic [31:0] n0, n1, n2, n3;
  logic [7:0]  rcon;

  always_comb begin
    rcon = 8'h00;
    unique case (rc)
      4'd0: rcon = 8'h01;
      4'd1: rcon = 8'h02;
      4'd2: rcon = 8'h04;
      4'd3: rcon = 8'h08;
      4'd4: rcon = 8'h10;
      4'd5: rcon = 8'h20;
      4'd6: rcon = 8'h40;
      4'd7: rcon = 8'h80;
      4'd8: rcon = 8'h1b;
      4'd9: rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign w0 = inkey[127:96];
  assign w1 = inkey[95:64];
  assign w2 = inkey[63:32];
  assign w3 = inkey[31:0];

  // RotWord then SubWord on the last word, Rcon folded into the top byte.
  assign rot = {w3[23:0], w3[31:24]};
  assign sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
  assign t   = sub ^ {rcon, 24'h000000};

  assign n0 = w0 ^ t;
  assign n1 = n0 ^ w1;
  assign n2 = n1 ^ w2;
  assign n3 = n2 ^ w3;

  assign outkey = {n0, n1, n2, n3};

endmodule

// File: rtl/key_schedule.sv
// rtl/key_schedule.sv - sequential AES-128 key expansion with round key store
//
// Purpose: accept a cipher key, expand one round key per cycle for 10 cycles,
// hold all 11 round keys and serve them through a registered read port.
// Ports:
//   clk          in  1    clock, rising edge
//   rst          in  1    asynchronous active-high reset
//   key_in       in  128  cipher key, byte 0 in [127:120]
//   key_valid    in  1    key_in valid this cycle
//   key_accept   out 1    a key can be accepted this cycle (IDLE or DONE)
//   busy         out 1    expansion in progress
//   keys_ready   out 1    all round keys valid
//   rk_idx       in  4    round key read index
//   rk_out       out 128  registered rk[rk_idx], 0 when not valid
//   rk_out_valid out 1    rk_out holds a valid key
module key_schedule
  import aes_pkg::*;
#(
  parameter int NUM_RK = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_accept,
  output logic         busy,
  output logic         keys_ready,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out,
  output logic         rk_out_valid
);

  localparam logic [3:0] LAST_RC = 4'(AES_ROUNDS - 1);
  localparam logic [3:0] MAX_IDX = 4'(NUM_RK - 1);

  ks_state_e  state_q, state_d;
  logic [3:0] cnt_q;
  rk_t        cur_q;
  rk_t        rk_q [NUM_RK];
  logic       keys_ready_q;
  rk_t        rk_out_q;
  logic       rk_out_valid_q;

  rk_t  nxt;
  logic accept;
  logic expand_step;
  logic last_step;
  logic read_ok;

  roundkey u_roundkey (
    .inkey  (cur_q),
    .rc     (cnt_q),
    .outkey (nxt)
  );

  assign key_accept  = (state_q == IDLE) || (state_q == DONE);
  assign accept      = key_valid && key_accept;
  assign expand_step = (state_q == EXPAND);
  assign last_step   = expand_step && (cnt_q == LAST_RC);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = EXPAND;
      EXPAND:  if (cnt_q == LAST_RC) state_d = DONE;
      DONE:    if (accept) state_d = EXPAND;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= 4'd0;
      cur_q        <= '0;
      keys_ready_q <= 1'b0;
      for (int i = 0; i < NUM_RK; i++) begin
        rk_q[i] <= '0;
      end
    end else if (accept) begin
      rk_q[0]      <= key_in;
      cur_q        <= key_in;
      cnt_q        <= 4'd0;
      keys_ready_q <= 1'b0;
    end else if (expand_step) begin
      rk_q[cnt_q + 4'd1] <= nxt;
      cur_q              <= nxt;
      if (last_step) begin
        keys_ready_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

  // Uses the pre-edge keys_ready, so a read sampled on a restart edge
  // still returns the previous schedule.
  assign read_ok = keys_ready_q && (rk_idx <= MAX_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rk_out_q       <= '0;
      rk_out_valid_q <= 1'b0;
    end else begin
      rk_out_valid_q <= read_ok;
      rk_out_q       <= read_ok ? rk_q[rk_idx] : '0;
    end
  end

  assign busy         = (state_q == EXPAND);
  assign keys_ready   = keys_ready_q;
  assign rk_out       = rk_out_q;
  assign rk_out_valid = rk_out_valid_q;

endmodule

// File: tb/tb_key_schedule.sv
// tb/tb_key_schedule.sv - self-checking bench for key_schedule
module tb_key_schedule;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_accept;
  logic         busy;
  logic         keys_ready;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;
  logic         rk_out_valid;

  int checks = 0;
  int errors = 0;

  logic [127:0] exp_rk [11];

  key_schedule #(.NUM_RK(11)) dut (
    .clk          (clk),
    .rst          (rst),
    .key_in       (key_in),
    .key_valid    (key_valid),
    .key_accept   (key_accept),
    .busy         (busy),
    .keys_ready   (keys_ready),
    .rk_idx       (rk_idx),
    .rk_out       (rk_out),
    .rk_out_valid (rk_out_valid)
  );

  always #5 clk = ~clk;

  // Reference model: S-box from GF(2^8) inverse plus affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_m(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    if (x != 8'h00) begin
      for (int c = 1; c < 256; c++) begin
        if (gmul(x, 8'(c)) == 8'h01) inv = 8'(c);
      end
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m(t[31:24]), sbox_m(t[23:16]), sbox_m(t[15:8]), sbox_m(t[7:0])};
        t = t ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Called at a negedge; presents the key for one edge and counts edges to ready.
  task automatic load_key(input logic [127:0] key, output int lat);
    key_in    = key;
    key_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    lat = 0;
    while (!keys_ready && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Called at a negedge; returns the registered read one edge later.
  task automatic do_read(input logic [3:0] idx, output logic [127:0] d, output logic v);
    rk_idx = idx;
    @(negedge clk);
    d = rk_out;
    v = rk_out_valid;
  endtask

  task automatic test_reset;
    logic [127:0] d;
    logic v;
    rst = 1'b1; key_valid = 1'b0; key_in = '0; rk_idx = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({key_accept, busy, keys_ready, rk_out_valid} !== 4'b1000 || rk_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs: acc/busy/rdy/vld=%b rk_out=%h, want 1000 and 0",
               {key_accept, busy, keys_ready, rk_out_valid}, rk_out);
    end
    do_read(4'd0, d, v);
    checks++;
    if (d !== '0 || v !== 1'b0) begin
      errors++;
      $display("FAIL read_not_ready: data=%h valid=%b, want 0/0", d, v);
    end
  endtask

  task automatic test_fips;
    logic [127:0] d;
    logic v;
    int lat;
    key_in = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    key_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || key_accept !== 1'b0) begin
      errors++;
      $display("FAIL fips_busy_after_accept: busy=%b accept=%b, want 1/0", busy, key_accept);
    end
    lat = 0;
    while (!keys_ready && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 10 || busy !== 1'b0) begin
      errors++;
      $display("FAIL fips_latency: edges=%0d busy=%b, want 10/0", lat, busy);
    end
    do_read(4'd1, d, v);
    checks++;
    if (d !== 128'ha0fafe1788542cb123a339392a6c7605 || v !== 1'b1) begin
      errors++;
      $display("FAIL fips_rk1: data=%h valid=%b, want a0fafe1788542cb123a339392a6c7605/1", d, v);
    end
    do_read(4'd10, d, v);
    checks++;
    if (d !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6 || v !== 1'b1) begin
      errors++;
      $display("FAIL fips_rk10: data=%h valid=%b, want d014f9a8c9ee2589e13f0cc8b6630ca6/1", d, v);
    end
  endtask

  task automatic test_zero_key;
    logic [127:0] d;
    logic v;
    int lat;
    load_key('0, lat);
    checks++;
    if (lat !== 10) begin
      errors++;
      $display("FAIL zero_latency: edges=%0d, want 10", lat);
    end
    do_read(4'd0, d, v);
    checks++;
    if (d !== '0 || v !== 1'b1) begin
      errors++;
      $display("FAIL zero_rk0: data=%h valid=%b, want 0/1", d, v);
    end
    do_read(4'd1, d, v);
    checks++;
    if (d !== 128'h62636363626363636263636362636363 || v !== 1'b1) begin
      errors++;
      $display("FAIL zero_rk1: data=%h valid=%b, want 62636363626363636263636362636363/1", d, v);
    end
    do_read(4'd10, d, v);
    checks++;
    if (d !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e || v !== 1'b1) begin
      errors++;
      $display("FAIL zero_rk10: data=%h valid=%b, want b4ef5bcb3e92e21123e951cf6f8f188e/1", d, v);
    end
  endtask

  task automatic test_read_bounds;
    logic [127:0] d;
    logic v;
    logic [127:0] key;
    int lat;
    key = {$urandom, $urandom, $urandom, $urandom};
    model_expand(key);
    load_key(key, lat);
    for (int r = 0; r < 16; r++) begin
      do_read(4'(r), d, v);
      checks++;
      if (r <= 10) begin
        if (d !== exp_rk[r] || v !== 1'b1) begin
          errors++;
          $display("FAIL bounds_rk%0d: data=%h valid=%b, want %h/1", r, d, v, exp_rk[r]);
        end
      end else if (d !== '0 || v !== 1'b0) begin
        errors++;
        $display("FAIL bounds_idx%0d: data=%h valid=%b, want 0/0", r, d, v);
      end
    end
  endtask

  task automatic test_handshake;
    logic [127:0] ka, kb;
    logic [127:0] a_rk10;
    logic [127:0] d;
    logic v;
    int lat;
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    model_expand(ka);
    a_rk10 = exp_rk[10];
    key_in = ka;
    key_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    key_in = kb;
    // After E0..E9 the unit is expanding and must refuse B.
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (key_accept !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL hs_expand_cycle%0d: accept=%b busy=%b, want 0/1", k, key_accept, busy);
      end
      if (k >= 1) begin
        checks++;
        if (rk_out !== '0 || rk_out_valid !== 1'b0) begin
          errors++;
          $display("FAIL hs_read_expand%0d: data=%h valid=%b, want 0/0", k, rk_out, rk_out_valid);
        end
      end
      rk_idx = 4'($urandom_range(0, 10));
      @(negedge clk);
    end
    checks++;
    if (keys_ready !== 1'b1 || key_accept !== 1'b1) begin
      errors++;
      $display("FAIL hs_first_done: ready=%b accept=%b, want 1/1", keys_ready, key_accept);
    end
    // B is accepted on the next edge; the read sampled there is still A's.
    rk_idx = 4'd10;
    @(negedge clk);
    key_valid = 1'b0;
    checks++;
    if (rk_out !== a_rk10 || rk_out_valid !== 1'b1 || keys_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL hs_a_result: data=%h valid=%b ready=%b busy=%b, want %h/1/0/1",
               rk_out, rk_out_valid, keys_ready, busy, a_rk10);
    end
    lat = 0;
    while (!keys_ready && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 10) begin
      errors++;
      $display("FAIL hs_b_latency: edges=%0d, want 10", lat);
    end
    model_expand(kb);
    for (int r = 0; r < 11; r++) begin
      do_read(4'(r), d, v);
      checks++;
      if (d !== exp_rk[r] || v !== 1'b1) begin
        errors++;
        $display("FAIL hs_b_rk%0d: data=%h valid=%b, want %h/1", r, d, v, exp_rk[r]);
      end
    end
  endtask

  task automatic test_async_reset;
    logic [127:0] d;
    logic v;
    int lat;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    key_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({key_accept, busy, keys_ready, rk_out_valid} !== 4'b1000 || rk_out !== '0) begin
      errors++;
      $display("FAIL async_reset: acc/busy/rdy/vld=%b rk_out=%h, want 1000 and 0",
               {key_accept, busy, keys_ready, rk_out_valid}, rk_out);
    end
    #1 rst = 1'b0;
    @(negedge clk);
    model_expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    load_key(128'h2b7e151628aed2a6abf7158809cf4f3c, lat);
    checks++;
    if (lat !== 10) begin
      errors++;
      $display("FAIL post_reset_latency: edges=%0d, want 10", lat);
    end
    for (int r = 0; r < 11; r++) begin
      do_read(4'(r), d, v);
      checks++;
      if (d !== exp_rk[r] || v !== 1'b1) begin
        errors++;
        $display("FAIL post_reset_rk%0d: data=%h valid=%b, want %h/1", r, d, v, exp_rk[r]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [127:0] k1, k2, old_rk;
    logic [127:0] d;
    logic v;
    logic [3:0] idx;
    int lat;
    for (int n = 0; n < 3; n++) begin
      k1 = {$urandom, $urandom, $urandom, $urandom};
      k2 = {$urandom, $urandom, $urandom, $urandom};
      model_expand(k1);
      load_key(k1, lat);
      idx = 4'($urandom_range(0, 10));
      old_rk = exp_rk[idx];
      rk_idx = idx;
      key_in = k2;
      key_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      key_valid = 1'b0;
      checks++;
      if (rk_out !== old_rk || rk_out_valid !== 1'b1 || keys_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_edge_read%0d: data=%h valid=%b ready=%b, want %h/1/0",
                 n, rk_out, rk_out_valid, keys_ready, old_rk);
      end
      lat = 0;
      while (!keys_ready && lat < 50) begin
        @(negedge clk);
        lat++;
      end
      checks++;
      if (lat !== 10) begin
        errors++;
        $display("FAIL b2b_latency%0d: edges=%0d, want 10", n, lat);
      end
      model_expand(k2);
      for (int r = 0; r < 11; r++) begin
        do_read(4'(r), d, v);
        checks++;
        if (d !== exp_rk[r] || v !== 1'b1) begin
          errors++;
          $display("FAIL b2b%0d_rk%0d: data=%h valid=%b, want %h/1", n, r, d, v, exp_rk[r]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fips();
    test_zero_key();
    test_read_bounds();
    test_handshake();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
